window_3x3_gen: RTL and testbench



---
 rtl/window_3x3_gen_pkg.sv | 14 +
 rtl/window_3x3_gen_line_buffer.sv | 26 ++
 rtl/window_3x3_gen.sv | 123 ++++++++++++
 tb/tb_window_3x3_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the filter pipeline: pixel width, default image
// geometry and the window generator's frame-tracking states.
package filter_pkg;

    localparam int PIX_W = 8;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage : filter_pkg

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of storage: single write port and a same-cycle read port,
// both addressed by the current column.
module line_buffer #(
    parameter int N = 8,
    parameter int W = 640
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [$clog2(W)-1:0] i_addr,
    input  logic [N-1:0]         i_wdata,
    output logic [N-1:0]         o_rdata
);

    logic [N-1:0] r_mem [W];

    // Read returns the pre-write value; a block-RAM mapping would need the
    // read pre-fetched one column ahead to keep this behaviour.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : line_buffer

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 window generator over a raster pixel stream; emits only fully
// interior windows, one cycle after the accepting edge.
module window_3x3_gen
    import filter_pkg::*;
#(
    parameter int N = PIX_W,
    parameter int W = IMG_W,
    parameter int H = IMG_H
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pixel_in,
    input  logic         pixel_valid,
    input  logic         sof,
    output logic [N-1:0] sw_pixel_1,
    output logic [N-1:0] sw_pixel_2,
    output logic [N-1:0] sw_pixel_3,
    output logic [N-1:0] sw_pixel_4,
    output logic [N-1:0] sw_pixel_5,
    output logic [N-1:0] sw_pixel_6,
    output logic [N-1:0] sw_pixel_7,
    output logic [N-1:0] sw_pixel_8,
    output logic [N-1:0] sw_pixel_9,
    output logic         act,
    output logic         eof,
    output state_t       o_dbg_state
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [N-1:0]  r_win [9];
    logic          r_act;
    logic          r_eof;

    logic          w_accept;
    logic          w_last;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [N-1:0]  w_lb0_rd;
    logic [N-1:0]  w_lb1_rd;

    // A sof beat is always (0,0), even when it lands on the last pixel slot.
    always_comb begin
        w_accept = pixel_valid && (sof || (r_state == ACTIVE));
        w_col    = sof ? '0 : r_col;
        w_row    = sof ? '0 : r_row;
        w_last   = !sof && (w_row == RW'(H - 1)) && (w_col == CW'(W - 1));
    end

    line_buffer #(.N(N), .W(W)) lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (pixel_in),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.N(N), .W(W)) lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_act   <= 1'b0;
            r_eof   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 3; k++) begin
                r_win[3*k]   <= r_win[3*k+1];
                r_win[3*k+1] <= r_win[3*k+2];
            end
            r_win[2] <= w_lb1_rd;
            r_win[5] <= w_lb0_rd;
            r_win[8] <= pixel_in;
            r_act    <= (w_row >= RW'(2)) && (w_col >= CW'(2));
            r_eof    <= w_last;
            if (w_last) begin
                r_state <= IDLE;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_state <= ACTIVE;
                if (w_col == CW'(W - 1)) begin
                    r_col <= '0;
                    r_row <= w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
        end else begin
            r_act <= 1'b0;
            r_eof <= 1'b0;
        end
    end

    assign sw_pixel_1  = r_win[0];
    assign sw_pixel_2  = r_win[1];
    assign sw_pixel_3  = r_win[2];
    assign sw_pixel_4  = r_win[3];
    assign sw_pixel_5  = r_win[4];
    assign sw_pixel_6  = r_win[5];
    assign sw_pixel_7  = r_win[6];
    assign sw_pixel_8  = r_win[7];
    assign sw_pixel_9  = r_win[8];
    assign act         = r_act;
    assign eof         = r_eof;
    assign o_dbg_state = r_state;

endmodule : window_3x3_gen

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image: directed frames plus randomized
// traffic, checked against an image-array reference model.
module tb_window_3x3_gen;
    import filter_pkg::*;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = 9 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pixel_in;
    logic         pixel_valid;
    logic         sof;
    logic [N-1:0] sw_pixel_1, sw_pixel_2, sw_pixel_3;
    logic [N-1:0] sw_pixel_4, sw_pixel_5, sw_pixel_6;
    logic [N-1:0] sw_pixel_7, sw_pixel_8, sw_pixel_9;
    logic         act;
    logic         eof;
    state_t       o_dbg_state;

    // clock / reset block
    always #5 clk = ~clk;

    window_3x3_gen #(.N(N), .W(W), .H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .sw_pixel_1  (sw_pixel_1),
        .sw_pixel_2  (sw_pixel_2),
        .sw_pixel_3  (sw_pixel_3),
        .sw_pixel_4  (sw_pixel_4),
        .sw_pixel_5  (sw_pixel_5),
        .sw_pixel_6  (sw_pixel_6),
        .sw_pixel_7  (sw_pixel_7),
        .sw_pixel_8  (sw_pixel_8),
        .sw_pixel_9  (sw_pixel_9),
        .act         (act),
        .eof         (eof),
        .o_dbg_state (o_dbg_state)
    );

    logic [WW-1:0] win_now;
    assign win_now = {sw_pixel_1, sw_pixel_2, sw_pixel_3,
                      sw_pixel_4, sw_pixel_5, sw_pixel_6,
                      sw_pixel_7, sw_pixel_8, sw_pixel_9};

    // reference model: the current frame as a 2-D image plus position
    logic [N-1:0]  img [H][W];
    bit            m_active;
    int            m_row;
    int            m_col;
    int            m_act_total;
    logic [WW-1:0] exp_q [$];

    int            total;
    int            bad;
    int            frame_act;
    int            act_total;
    int            eof_cnt;
    logic [WW-1:0] first_win;
    logic [WW-1:0] last_win;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_row    = 0;
        m_col    = 0;
        exp_q.delete();
    endtask

    task automatic clear_stats();
        frame_act = 0;
        eof_cnt   = 0;
        first_win = '0;
        last_win  = '0;
    endtask

    // driver: one clock cycle with the given inputs, then check the outputs
    task automatic beat(input bit v, input bit s, input logic [N-1:0] px);
        bit            exp_act;
        bit            exp_eof;
        int            r;
        int            c;
        logic [WW-1:0] w;
        pixel_valid = v;
        sof         = s;
        pixel_in    = px;
        exp_act     = 1'b0;
        exp_eof     = 1'b0;
        if (v && (s || m_active)) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = px;
            if (r >= 2 && c >= 2) begin
                exp_act = 1'b1;
                w = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w = {w[WW-N-1:0], img[r-2+i][c-2+j]};
                exp_q.push_back(w);
                m_act_total++;
            end
            exp_eof = !s && (r == H - 1) && (c == W - 1);
            if (exp_eof) begin
                m_active = 1'b0;
                m_row    = 0;
                m_col    = 0;
            end else begin
                m_active = 1'b1;
                m_row    = (c == W - 1) ? r + 1 : r;
                m_col    = (c == W - 1) ? 0 : c + 1;
            end
        end
        @(posedge clk);
        #1;
        check_val("act", WW'(act), WW'(exp_act));
        check_val("eof", WW'(eof), WW'(exp_eof));
        check_val("state", WW'(o_dbg_state == ACTIVE), WW'(m_active));
        if (eof) eof_cnt++;
        if (act) begin
            if (frame_act == 0) first_win = win_now;
            last_win = win_now;
            frame_act++;
            act_total++;
            check_val("win_pending", WW'(exp_q.size() > 0), WW'(1));
            if (exp_q.size() > 0) check_val("win", win_now, exp_q.pop_front());
        end
    endtask

    task automatic send_frame(input logic [N-1:0] base, input int stall_at);
        for (int i = 0; i < W * H; i++) begin
            if (i == stall_at) repeat (3) beat(1'b0, 1'b0, 8'hEE);
            beat(1'b1, i == 0, base + N'(i));
        end
    endtask

    task automatic check_frame(input string tag, input int acts, input int eofs,
                               input logic [WW-1:0] fw, input logic [WW-1:0] lw);
        check_val({tag, "_acts"}, WW'(frame_act), WW'(acts));
        check_val({tag, "_eofs"}, WW'(eof_cnt), WW'(eofs));
        check_val({tag, "_first"}, first_win, fw);
        check_val({tag, "_last"}, last_win, lw);
    endtask

    initial begin
        total = 0;
        bad = 0;
        act_total = 0;
        m_act_total = 0;
        model_reset();
        clear_stats();
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        sof = 1'b0;
        pixel_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_win", win_now, '0);
        check_val("rst_act", WW'(act), '0);
        check_val("rst_eof", WW'(eof), '0);
        check_val("rst_state", WW'(o_dbg_state == ACTIVE), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // plain frame
        send_frame(8'h10, -1);
        beat(1'b0, 1'b0, 8'h00);
        check_frame("s1", 4, 1, 72'h10_11_12_14_15_16_18_19_1A, 72'h15_16_17_19_1A_1B_1D_1E_1F);

        // mid-line stall
        clear_stats();
        send_frame(8'h10, 10);
        check_frame("s2", 4, 1, 72'h10_11_12_14_15_16_18_19_1A, 72'h15_16_17_19_1A_1B_1D_1E_1F);

        // beats without sof are dropped while idle
        clear_stats();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 8'hA0 + N'(i));
        send_frame(8'h10, -1);
        check_frame("s3", 4, 1, 72'h10_11_12_14_15_16_18_19_1A, 72'h15_16_17_19_1A_1B_1D_1E_1F);

        // sof restart at row 2, col 1
        clear_stats();
        for (int i = 0; i < 9; i++) beat(1'b1, i == 0, 8'h10 + N'(i));
        check_val("s4_partial_acts", WW'(frame_act), '0);
        send_frame(8'h20, -1);
        check_frame("s4", 4, 1, 72'h20_21_22_24_25_26_28_29_2A, 72'h25_26_27_29_2A_2B_2D_2E_2F);

        // sof lands on the last pixel slot: restart wins, no eof
        clear_stats();
        for (int i = 0; i < W * H - 1; i++) beat(1'b1, i == 0, 8'h40 + N'(i));
        send_frame(8'h30, -1);
        check_frame("s4b", 7, 1, 72'h40_41_42_44_45_46_48_49_4A, 72'h35_36_37_39_3A_3B_3D_3E_3F);

        // asynchronous reset at row 3, col 0
        clear_stats();
        for (int i = 0; i < 3 * W; i++) beat(1'b1, i == 0, 8'h50 + N'(i));
        beat(1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        check_val("s5_rst_win", win_now, '0);
        check_val("s5_rst_act", WW'(act), '0);
        check_val("s5_rst_state", WW'(o_dbg_state == ACTIVE), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 8'h60 + N'(i));
        check_val("s5_ignored", win_now, '0);
        clear_stats();
        send_frame(8'h10, -1);
        check_frame("s5", 4, 1, 72'h10_11_12_14_15_16_18_19_1A, 72'h15_16_17_19_1A_1B_1D_1E_1F);

        // randomized traffic: random stalls, pixels and occasional sof restarts
        beat(1'b1, 1'b1, N'($urandom));
        for (int i = 0; i < 600; i++) begin
            bit v;
            v = ($urandom_range(0, 9) < 8);
            beat(v, v && ($urandom_range(0, 39) == 0), N'($urandom));
        end
        beat(1'b0, 1'b0, 8'h00);
        check_val("rand_act_total", WW'(act_total), WW'(m_act_total));
        check_val("rand_q_empty", WW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_window_3x3_gen
